// File: rtl/turn_timer_ctrl.sv
// Two-player turn timer: per-player tick countdown, pause/resume, expiry flags, move counter.
// Optional build macro TURN_TIMER_INCREMENT_EN adds INC_VALUE to the player ending a turn.
module turn_timer_ctrl #(
   parameter logic [15:0] START_VALUE = 16'd30,
   parameter logic [15:0] INC_VALUE   = 16'd5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        set,
   input  logic        btn_a,
   input  logic        btn_b,
   input  logic        pause,
   output logic [15:0] time_a,
   output logic [15:0] time_b,
   output logic [2:0]  state,
   output logic        flag_a,
   output logic        flag_b,
   output logic [7:0]  move_count
);

   localparam int unsigned TW = 16;
   localparam int unsigned MW = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN_A   = 3'd1,
      RUN_B   = 3'd2,
      PAUSED  = 3'd3,
      EXPIRED = 3'd4
   } state_t;

   state_t          state_q, state_n;
   logic [TW-1:0]   time_a_n, time_b_n;
   logic            flag_a_n, flag_b_n;
   logic [MW-1:0]   move_n;
   logic            side_q, side_n;      // 0 = A was running when paused, 1 = B

   // Running-side helpers shared by RUN_A and RUN_B
   logic            on_b;
   logic [TW-1:0]   run_t;
   logic            run_btn;
   logic [TW-1:0]   run_t_dec;
   logic [TW-1:0]   run_t_sw;
   logic [TW-1:0]   run_t_n;
   logic            run_expire;
   logic            do_reload;
   logic [MW-1:0]   move_inc;

`ifdef TURN_TIMER_INCREMENT_EN
   function automatic logic [TW-1:0] add_inc(input logic [TW-1:0] t);
      logic [TW:0] s;
      s = {1'b0, t} + {1'b0, INC_VALUE};
      return s[TW] ? {TW{1'b1}} : s[TW-1:0];
   endfunction
`else
   logic unused_inc_value;
   assign unused_inc_value = ^INC_VALUE;
`endif

   assign state = state_q;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         time_a     <= '0;
         time_b     <= '0;
         flag_a     <= 1'b0;
         flag_b     <= 1'b0;
         move_count <= '0;
         side_q     <= 1'b0;
      end else begin
         state_q    <= state_n;
         time_a     <= time_a_n;
         time_b     <= time_b_n;
         flag_a     <= flag_a_n;
         flag_b     <= flag_b_n;
         move_count <= move_n;
         side_q     <= side_n;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_n    = state_q;
      time_a_n   = time_a;
      time_b_n   = time_b;
      flag_a_n   = flag_a;
      flag_b_n   = flag_b;
      move_n     = move_count;
      side_n     = side_q;
      do_reload  = 1'b0;

      on_b       = (state_q == RUN_B);
      run_t      = on_b ? time_b : time_a;
      run_btn    = on_b ? btn_b : btn_a;
      run_expire = tick && (run_t == TW'(1));
      run_t_dec  = (tick && (run_t != '0)) ? run_t - TW'(1) : run_t;
`ifdef TURN_TIMER_INCREMENT_EN
      run_t_sw   = add_inc(run_t_dec);
`else
      run_t_sw   = run_t_dec;
`endif
      run_t_n    = run_t_dec;
      move_inc   = (move_count == {MW{1'b1}}) ? move_count : move_count + MW'(1);

      case (state_q)
         IDLE: begin
            if (set) begin
               do_reload = 1'b1;
            end else if ((btn_a != btn_b) && (time_a != '0) && (time_b != '0)) begin
               state_n = btn_a ? RUN_B : RUN_A;
            end
         end

         RUN_A, RUN_B: begin
            // Expiry beats both pause and the turn switch; a tick always lands first
            if (run_expire) begin
               state_n = EXPIRED;
            end else if (pause) begin
               state_n = PAUSED;
               side_n  = on_b;
            end else if (run_btn) begin
               run_t_n = run_t_sw;
               state_n = on_b ? RUN_A : RUN_B;
               move_n  = move_inc;
            end
            if (on_b) begin
               time_b_n = run_t_n;
               flag_b_n = flag_b | run_expire;
            end else begin
               time_a_n = run_t_n;
               flag_a_n = flag_a | run_expire;
            end
         end

         PAUSED: begin
            if (set) begin
               do_reload = 1'b1;
            end else if (pause) begin
               state_n = side_q ? RUN_B : RUN_A;
            end
         end

         EXPIRED: begin
            if (set) begin
               do_reload = 1'b1;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      if (do_reload) begin
         state_n  = IDLE;
         time_a_n = START_VALUE;
         time_b_n = START_VALUE;
         flag_a_n = 1'b0;
         flag_b_n = 1'b0;
      end
   end

endmodule
